// File: rtl/dmg_irq_pkg.sv
// Shared definitions for the DMG interrupt controller.
//   - default IF/IE register addresses
//   - request source bit indices
//   - write-path FSM state encoding
package dmg_irq_pkg;

    localparam logic [15:0] IRQ_IF_ADDR = 16'hFF0F;
    localparam logic [15:0] IRQ_IE_ADDR = 16'hFFFF;

    localparam int unsigned IRQ_VBLANK = 0;
    localparam int unsigned IRQ_STAT   = 1;
    localparam int unsigned IRQ_TIMER  = 2;
    localparam int unsigned IRQ_SERIAL = 3;
    localparam int unsigned IRQ_JOYPAD = 4;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_CAPTURE = 2'd1,
        WR_COMMIT  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/dmg_irq_edge.sv
// Registered rising-edge detector for the peripheral request lines.
// Ports:
//   CLK     in   clock
//   RESET   in   synchronous active-high reset
//   i_src   in   WIDTH request lines (level)
//   o_rise  out  WIDTH one-cycle rise flags (combinational from i_src)
module dmg_irq_edge #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] i_src,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;
    logic             r_armed;

    // r_armed stays low for the first cycle after reset so a line already
    // high at release only reloads r_prev and never reports a rise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_src;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_src & ~r_prev & {WIDTH{r_armed}};

endmodule

// File: rtl/dmg_irq_ctrl.sv
// DMG interrupt controller: latches request edges into IF, masks with IE,
// drives CPU_IRQ_TRIG toward the core and accepts its acknowledge.
// Optional feature macro: DMG_IRQ_OVERRUN_EN (overrun counter + sticky flag).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   A, D_IN, RD, WR   core bus (address, write data, read/write strobes)
//   D_OUT, D_OE       read data and its drive enable
//   IRQ_SRC           peripheral request lines (level)
//   CPU_IRQ_TRIG      registered pending & enabled requests
//   CPU_IRQ_ACK       one-hot acknowledge from the core
//   IRQ_OVERRUN_CNT   saturating overrun count      (DMG_IRQ_OVERRUN_EN only)
//   IRQ_OVERRUN_FLAG  sticky overrun indicator      (DMG_IRQ_OVERRUN_EN only)
module dmg_irq_ctrl
    import dmg_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 5,
    parameter logic [15:0] IF_ADDR = IRQ_IF_ADDR,
    parameter logic [15:0] IE_ADDR = IRQ_IE_ADDR
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [15:0]        A,
    input  logic [7:0]         D_IN,
    output logic [7:0]         D_OUT,
    output logic               D_OE,
    input  logic               RD,
    input  logic               WR,
    input  logic [NUM_IRQ-1:0] IRQ_SRC,
    output logic [7:0]         CPU_IRQ_TRIG,
`ifdef DMG_IRQ_OVERRUN_EN
    output logic [7:0]         IRQ_OVERRUN_CNT,
    output logic               IRQ_OVERRUN_FLAG,
`endif
    input  logic [7:0]         CPU_IRQ_ACK
);

    wr_state_t          r_state;
    logic               r_to_ie;
    logic [7:0]         r_data;
    logic [NUM_IRQ-1:0] r_if;
    logic [7:0]         r_ie;
    logic [7:0]         r_trig;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_ack;
    logic [NUM_IRQ-1:0] w_if_next;
    logic [7:0]         w_ie_next;
    logic [7:0]         w_trig_next;
    logic [7:0]         w_if_rd;
    logic               w_if_hit;
    logic               w_ie_hit;
    logic               w_unused_ack;

    dmg_irq_edge #(.WIDTH(NUM_IRQ)) u_edge (
        .CLK    (CLK),
        .RESET  (RESET),
        .i_src  (IRQ_SRC),
        .o_rise (w_rise)
    );

    assign w_if_hit     = (A == IF_ADDR);
    assign w_ie_hit     = (A == IE_ADDR);
    assign w_ack        = CPU_IRQ_ACK[NUM_IRQ-1:0];
    assign w_unused_ack = ^CPU_IRQ_ACK;

    // Priority: commit write, then ack clear, then rise set (set wins).
    always_comb begin
        w_if_next = r_if;
        w_ie_next = r_ie;
        if (r_state == WR_COMMIT) begin
            if (r_to_ie) w_ie_next = r_data;
            else         w_if_next = r_data[NUM_IRQ-1:0];
        end
        w_if_next = (w_if_next & ~w_ack) | w_rise;
        w_trig_next = '0;
        w_trig_next[NUM_IRQ-1:0] = w_if_next & w_ie_next[NUM_IRQ-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= WR_IDLE;
            r_to_ie <= 1'b0;
            r_data  <= '0;
            r_if    <= '0;
            r_ie    <= '0;
            r_trig  <= '0;
        end else begin
            r_if   <= w_if_next;
            r_ie   <= w_ie_next;
            r_trig <= w_trig_next;
            case (r_state)
                WR_IDLE: begin
                    if (WR && (w_if_hit || w_ie_hit)) begin
                        r_state <= WR_CAPTURE;
                        r_to_ie <= w_ie_hit;
                        r_data  <= D_IN;
                    end
                end
                WR_CAPTURE: begin
                    if (WR) r_data  <= D_IN;
                    else    r_state <= WR_COMMIT;
                end
                WR_COMMIT: r_state <= WR_IDLE;
                default:   r_state <= WR_IDLE;
            endcase
        end
    end

    assign CPU_IRQ_TRIG = r_trig;

    // Reads see the registered values, so a read in COMMIT returns pre-write data.
    always_comb begin
        w_if_rd = 8'hFF;
        w_if_rd[NUM_IRQ-1:0] = r_if;
        D_OE  = 1'b0;
        D_OUT = 8'hFF;
        if (RD && w_if_hit) begin
            D_OE  = 1'b1;
            D_OUT = w_if_rd;
        end else if (RD && w_ie_hit) begin
            D_OE  = 1'b1;
            D_OUT = r_ie;
        end
    end

`ifdef DMG_IRQ_OVERRUN_EN
    logic       w_overrun;
    logic [7:0] r_ovr_cnt;
    logic       r_ovr_flag;

    assign w_overrun = |(w_rise & r_if & ~w_ack);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovr_cnt  <= '0;
            r_ovr_flag <= 1'b0;
        end else if (w_overrun) begin
            r_ovr_flag <= 1'b1;
            if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign IRQ_OVERRUN_CNT  = r_ovr_cnt;
    assign IRQ_OVERRUN_FLAG = r_ovr_flag;
`endif

endmodule

// File: tb/tb_dmg_irq_ctrl.sv
module tb_dmg_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic [4:0]  IRQ_SRC;
    logic [7:0]  CPU_IRQ_TRIG;
    logic [7:0]  CPU_IRQ_ACK;
`ifdef DMG_IRQ_OVERRUN_EN
    logic [7:0]  IRQ_OVERRUN_CNT;
    logic        IRQ_OVERRUN_FLAG;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  rd_d;
    logic        rd_oe;

    always #5 CLK = ~CLK;

    dmg_irq_ctrl #(.NUM_IRQ(5), .IF_ADDR(16'hFF0F), .IE_ADDR(16'hFFFF)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .A            (A),
        .D_IN         (D_IN),
        .D_OUT        (D_OUT),
        .D_OE         (D_OE),
        .RD           (RD),
        .WR           (WR),
        .IRQ_SRC      (IRQ_SRC),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
`ifdef DMG_IRQ_OVERRUN_EN
        .IRQ_OVERRUN_CNT  (IRQ_OVERRUN_CNT),
        .IRQ_OVERRUN_FLAG (IRQ_OVERRUN_FLAG),
`endif
        .CPU_IRQ_ACK  (CPU_IRQ_ACK)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Step one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_rd(input logic [15:0] addr, output logic [7:0] d, output logic oe);
        A  = addr;
        RD = 1'b1;
        #1;
        d  = D_OUT;
        oe = D_OE;
        RD = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; A = 16'h0000; D_IN = 8'h00; RD = 1'b0; WR = 1'b0;
        IRQ_SRC = 5'b00000; CPU_IRQ_ACK = 8'h00;
        tick(2);
        // source already high while reset releases: must not latch
        IRQ_SRC = 5'b00001;
        tick(1);
        RESET = 1'b0;
        tick(1);
        check("rst_trig", CPU_IRQ_TRIG, 8'h00);
        check("rst_doe", {7'd0, D_OE}, 8'h00);
        check("rst_dout", D_OUT, 8'hFF);
        tick(2);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("rel_high_if", rd_d, 8'hE0);
        IRQ_SRC = 5'b00000;
        tick(1);

        // 1: VBlank rise with IE=0
        IRQ_SRC = 5'b00001;
        tick(1);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t1_if", rd_d, 8'hE1);
        check("t1_oe", {7'd0, rd_oe}, 8'h01);
        check("t1_trig", CPU_IRQ_TRIG, 8'h00);
        CPU_IRQ_ACK = 8'h01;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t1_ack_if", rd_d, 8'hE0);

        // 2: IE write held 3 cycles; data relatched during CAPTURE
        A = 16'hFFFF; D_IN = 8'h33; WR = 1'b1;
        tick(1);
        D_IN = 8'h05;
        tick(2);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t2_ie_pre", rd_d, 8'h00);
        WR = 1'b0; D_IN = 8'hAA;
        tick(1);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t2_ie_commit_cyc", rd_d, 8'h00);
        tick(1);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t2_ie", rd_d, 8'h05);
        check("t2_trig0", CPU_IRQ_TRIG, 8'h00);
        IRQ_SRC = 5'b00101;
        tick(1);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t2_if", rd_d, 8'hE4);
        check("t2_trig", CPU_IRQ_TRIG, 8'h04);

        // 3: ack TIMER
        CPU_IRQ_ACK = 8'h04;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t3_if", rd_d, 8'hE0);
        check("t3_trig", CPU_IRQ_TRIG, 8'h00);

        // 4: rise and ack of TIMER in the same cycle -> set wins
        IRQ_SRC = 5'b00001;
        tick(1);
        IRQ_SRC = 5'b00101; CPU_IRQ_ACK = 8'h04;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t4_if", rd_d, 8'hE4);
        check("t4_trig", CPU_IRQ_TRIG, 8'h04);

        // 5: IF write of 0 with VBlank rising in the COMMIT cycle
        IRQ_SRC = 5'b00100;
        tick(1);
        A = 16'hFF0F; D_IN = 8'h00; WR = 1'b1;
        tick(2);
        WR = 1'b0;
        tick(1);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t5_if_pre", rd_d, 8'hE4);
        IRQ_SRC = 5'b00101;
        tick(1);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t5_if", rd_d, 8'hE1);
        check("t5_trig", CPU_IRQ_TRIG, 8'h01);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t5_ie", rd_d, 8'h05);
        check("t5_ie_oe", {7'd0, rd_oe}, 8'h01);
        bus_rd(16'hFF10, rd_d, rd_oe);
        check("t5_miss_oe", {7'd0, rd_oe}, 8'h00);
        check("t5_miss_d", rd_d, 8'hFF);
        // write to an unrelated address has no effect
        A = 16'hFF10; D_IN = 8'hFF; WR = 1'b1;
        tick(2);
        WR = 1'b0;
        tick(3);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t5_other_ie", rd_d, 8'h05);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t5_other_if", rd_d, 8'hE1);

`ifdef DMG_IRQ_OVERRUN_EN
        check("ovr_cnt0", IRQ_OVERRUN_CNT, 8'h00);
        IRQ_SRC = 5'b00100;
        tick(1);
        IRQ_SRC = 5'b00101;
        tick(1);
        check("ovr_cnt1", IRQ_OVERRUN_CNT, 8'h01);
        check("ovr_flag", {7'd0, IRQ_OVERRUN_FLAG}, 8'h01);
`endif

        // 6: reset while in CAPTURE discards the write
        A = 16'hFFFF; D_IN = 8'hFF; WR = 1'b1;
        tick(1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0; WR = 1'b0;
        tick(3);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t6_ie", rd_d, 8'h00);
        bus_rd(16'hFF0F, rd_d, rd_oe);
        check("t6_if", rd_d, 8'hE0);
        check("t6_trig", CPU_IRQ_TRIG, 8'h00);
`ifdef DMG_IRQ_OVERRUN_EN
        check("t6_ovr_cnt", IRQ_OVERRUN_CNT, 8'h00);
`endif
        // FSM back in IDLE: a fresh IE write lands normally
        A = 16'hFFFF; D_IN = 8'h1F; WR = 1'b1;
        tick(1);
        WR = 1'b0;
        tick(2);
        bus_rd(16'hFFFF, rd_d, rd_oe);
        check("t6_idle_wr", rd_d, 8'h1F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
